// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor / redirect controller.
package branch_pkg;

    // 2-bit saturating prediction counter
    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Bit positions of the jump/branch flags inside the decoder's BrOp field
    localparam int unsigned BROP_JUMP_BIT   = 4;
    localparam int unsigned BROP_BRANCH_BIT = 3;

    // Flush down-counter width (FLUSH_CYCLES is limited to 1..7)
    localparam int unsigned FLUSH_CNT_BITS = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Saturating increment towards strongly-taken
    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + ctr_t'(1));
    endfunction

    // Saturating decrement towards strongly-not-taken
    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - ctr_t'(1));
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: combinational fetch lookup, combinational
// resolve-side probe of the same array, one synchronous write port,
// and valid bits cleared asynchronously by reset.
module btb_table
    import branch_pkg::*;
#(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned TAG_BITS = 26,
    parameter int unsigned XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch lookup
    input  logic [IDX_BITS-1:0] lk_idx,
    output logic                lk_valid_c,
    output logic [TAG_BITS-1:0] lk_tag_c,
    output logic [XLEN-1:0]     lk_target_c,
    output ctr_t                lk_ctr_c,
    // resolve-side probe (read half of the read-modify-write update)
    input  logic [IDX_BITS-1:0] pr_idx,
    output logic                pr_valid_c,
    output logic [TAG_BITS-1:0] pr_tag_c,
    output logic [XLEN-1:0]     pr_target_c,
    output ctr_t                pr_ctr_c,
    // write port
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [XLEN-1:0]     wr_target,
    input  ctr_t                wr_ctr
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];

    // Valid bits: cleared by reset, set on any write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload needs no reset; it is ignored while valid is low
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_ctr;
        end
    end

    // Read ports return pre-write contents (no bypass)
    assign lk_valid_c  = valid_q[lk_idx];
    assign lk_tag_c    = tag_q[lk_idx];
    assign lk_target_c = target_q[lk_idx];
    assign lk_ctr_c    = ctr_q[lk_idx];

    assign pr_valid_c  = valid_q[pr_idx];
    assign pr_tag_c    = tag_q[pr_idx];
    assign pr_target_c = target_q[pr_idx];
    assign pr_ctr_c    = ctr_q[pr_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and redirect controller: BTB lookup for fetch,
// resolve-time table update, mispredict redirect + flush, statistics.
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned IDX_BITS     = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;

    logic                lk_valid, pr_valid;
    logic [TAG_BITS-1:0] lk_tag, pr_tag;
    logic [XLEN-1:0]     lk_target, pr_target;
    ctr_t                lk_ctr, pr_ctr;

    logic                wr_en;
    logic [XLEN-1:0]     wr_target;
    ctr_t                wr_ctr;

    logic lk_hit, pr_hit, res, eff_taken, mp;

    state_t                    state_q, state_d;
    logic [FLUSH_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                      redirect_valid_d, flush_d;
    logic [XLEN-1:0]           redirect_pc_d;
    logic [31:0]               br_count_d, mispred_count_d;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];

    btb_table #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS),
        .XLEN     (XLEN)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_idx      (if_idx),
        .lk_valid_c  (lk_valid),
        .lk_tag_c    (lk_tag),
        .lk_target_c (lk_target),
        .lk_ctr_c    (lk_ctr),
        .pr_idx      (ex_idx),
        .pr_valid_c  (pr_valid),
        .pr_tag_c    (pr_tag),
        .pr_target_c (pr_target),
        .pr_ctr_c    (pr_ctr),
        .wr_en       (wr_en),
        .wr_idx      (ex_idx),
        .wr_tag      (ex_tag),
        .wr_target   (wr_target),
        .wr_ctr      (wr_ctr)
    );

    // Zero-latency fetch prediction
    assign lk_hit      = lk_valid && (lk_tag == if_tag);
    assign pred_taken  = lk_hit && lk_ctr[1];
    assign pred_target = lk_hit ? lk_target : if_pc + XLEN'(4);

    // Resolve qualification and mispredict detection; jumps are always taken
    assign pr_hit    = pr_valid && (pr_tag == ex_tag);
    assign res       = ex_valid && (ex_is_branch || ex_is_jump) && (state_q == IDLE);
    assign eff_taken = ex_taken || ex_is_jump;
    assign mp        = res && ((eff_taken != ex_pred_taken) ||
                               (eff_taken && ex_pred_taken && (ex_target != ex_pred_target)));

    // BTB update: counter training on hit, allocation on taken miss
    always_comb begin
        wr_en     = 1'b0;
        wr_target = pr_target;
        wr_ctr    = pr_ctr;
        if (res) begin
            if (pr_hit) begin
                wr_en = 1'b1;
                if (ex_is_jump) begin
                    wr_ctr    = ST;
                    wr_target = ex_target;
                end else if (ex_taken) begin
                    wr_ctr    = ctr_inc(pr_ctr);
                    wr_target = ex_target;
                end else begin
                    wr_ctr    = ctr_dec(pr_ctr);
                end
            end else if (eff_taken) begin
                wr_en     = 1'b1;
                wr_target = ex_target;
                wr_ctr    = ex_is_jump ? ST : WT;
            end
        end
    end

    // Next-state, redirect/flush and statistics
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        flush_d          = 1'b0;
        br_count_d       = br_count;
        mispred_count_d  = mispred_count;

        if (res && (br_count != 32'hFFFF_FFFF)) begin
            br_count_d = br_count + 32'd1;
        end
        if (mp && (mispred_count != 32'hFFFF_FFFF)) begin
            mispred_count_d = mispred_count + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (mp) begin
                    state_d          = FLUSH;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = eff_taken ? ex_target : ex_pc + XLEN'(4);
                    flush_d          = 1'b1;
                    cnt_d            = FLUSH_CNT_BITS'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - FLUSH_CNT_BITS'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            br_count       <= br_count_d;
            mispred_count  <= mispred_count_d;
        end
    end

endmodule
